apb_req_bridge6: RTL and testbench
==================================

Name: apb_req_bridge6

Overview:
- Converts a simple valid/ready request channel into single APB transfers on the apb_master_if6 signal set: paddr6, prwd6, pwdata6, psel6, penable6, pready6, prdata6, pslverr6.
- Sits directly upstream of the APB master interface and is the RTL driver of those signals.
- Returns one response per request: read data, slave error and timeout.
- Decodes 16 one-hot slave selects and aborts transfers that wait too long.

Parameters:
- PADDR_WIDTH6, 32, APB address width.
- PWDATA_WIDTH6, 32, write data width.
- PRDATA_WIDTH6, 32, read data width.
- NUM_SLAVES, 16, populated psel6 slots (1..16).
- SEL_LSB, 12, lowest address bit of the 4-bit slave index: index = paddr[SEL_LSB+3:SEL_LSB].
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with pready6 low; 0 disables the timeout.

Ports:
- pclock6  in  1  APB clock; all logic is on the rising edge.
- preset6  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  PADDR_WIDTH6  target address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  PWDATA_WIDTH6  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  PRDATA_WIDTH6  read data; 0 for writes and for errors.
- rsp_slverr  out  1  slave error, decode error or timeout.
- rsp_timeout  out  1  transfer aborted by the timeout.
- paddr6  out  PADDR_WIDTH6  APB address.
- prwd6  out  1  APB direction, 1 = write.
- pwdata6  out  PWDATA_WIDTH6  APB write data.
- psel6  out  16  one-hot APB slave select.
- penable6  out  1  APB enable.
- pready6  in  1  slave ready.
- prdata6  in  PRDATA_WIDTH6  slave read data.
- pslverr6  in  1  slave error; sampled only together with pready6.

Behaviour:
- Reset (preset6 low, asynchronous): state = IDLE. All outputs are 0: psel6, penable6, paddr6, prwd6, pwdata6, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout. The timeout counter is 0.
  - Reset asserted mid-transfer: the transfer and any pending response are discarded, and psel6/penable6 drop immediately.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1 only in IDLE; req_ready is combinational from state.
  - Accept on req_valid && req_ready: register req_addr into paddr6, req_write into prwd6, and req_wdata into pwdata6. pwdata6 is 0 for reads.
  - Decode error (index >= NUM_SLAVES): no APB transfer; go to RESP with rsp_slverr = 1, rsp_timeout = 0, rsp_rdata = 0. Response latency is 1 cycle after accept.
  - Otherwise go to SETUP.
- SETUP: psel6[index] = 1, penable6 = 0. Exactly 1 cycle, then ACCESS.
- ACCESS:
  - psel6 is held and penable6 = 1; paddr6, prwd6 and pwdata6 are stable.
  - Each cycle with pready6 low increments the counter.
  - pready6 high completes the transfer:
    - capture rsp_slverr = pslverr6;
    - capture rsp_rdata = prdata6 for a read with no error, else 0;
    - rsp_timeout = 0; go to RESP.
  - Timeout: with TIMEOUT_CYCLES > 0, if the counter reaches TIMEOUT_CYCLES while pready6 is still low, abort: go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready6 high in the same cycle the counter reaches the limit: completion wins, no timeout.
  - The counter clears on leaving ACCESS.
- RESP:
  - psel6 = 0 and penable6 = 0 from the first RESP cycle; rsp_valid = 1.
  - Response fields are held until rsp_valid && rsp_ready; then rsp_valid clears and the state returns to IDLE.
  - paddr6, prwd6 and pwdata6 keep their last values until the next accept.
- Timing:
  - With zero wait states and rsp_ready tied to 1, accept-to-rsp_valid latency is 3 cycles (SETUP, ACCESS, then rsp_valid rises).
  - Minimum issue interval is 4 cycles; there is no pipelining or back-to-back SETUP.
- Invariants:
  - psel6 is always one-hot or 0.
  - penable6 is never 1 while psel6 is 0.
  - Outputs are never X after reset.

Decomposition:
- Package apb_bridge_pkg6 holds:
  - state enum apb_br_state_e (IDLE, SETUP, ACCESS, RESP);
  - localparam SEL_BITS = 4;
  - function decode_psel(index) returning the 16-bit one-hot select.
- Sub-module apb_wait_timer6:
  - inputs: clear, count enable (ACCESS && !pready6);
  - output: expired when count == TIMEOUT_CYCLES;
  - counter width $clog2(TIMEOUT_CYCLES+1);
  - constant 0 output when TIMEOUT_CYCLES = 0.

Test Plan:
- Read with zero wait states: addr 0x0000_3004, pready6 = 1 in ACCESS, prdata6 = 0xDEAD_BEEF. Required: psel6 = 0x0008 for 2 cycles, penable6 high for 1 cycle, rsp_rdata = 0xDEADBEEF, rsp_slverr = 0, rsp_valid 3 cycles after accept.
- Write with 3 wait states: addr 0x0000_0010, wdata 0xA5A5_0001. Required: psel6 = 0x0001, penable6 high for 4 cycles, paddr6 and pwdata6 stable throughout, rsp_rdata = 0, rsp_slverr = 0.
- Slave error: read with pslverr6 = 1 and pready6 = 1. Required: rsp_slverr = 1, rsp_rdata = 0. Response held while rsp_ready = 0 for 5 cycles, req_ready = 0 during the hold.
- Timeout and decode error:
  - TIMEOUT_CYCLES = 8, pready6 stuck low: required abort after 8 ACCESS cycles, psel6 = 0, rsp_timeout = 1, rsp_slverr = 1.
  - Rerun with pready6 rising exactly on cycle 8: required normal completion.
  - NUM_SLAVES = 4, addr 0x0000_5000: required no psel6 activity and rsp_slverr = 1 one cycle after accept.
- Reset during ACCESS with a 2-cycle preset6 pulse: required psel6, penable6 and rsp_valid at 0 asynchronously, state IDLE, req_ready = 1 after release, next read completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg6.sv
// Shared types and helpers for the valid/ready to APB request bridge.
package apb_bridge_pkg6;

  localparam int SEL_BITS = 4;
  localparam int NUM_SEL  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_br_state_e;

  function automatic logic [NUM_SEL-1:0] decode_psel(input logic [SEL_BITS-1:0] index);
    decode_psel = NUM_SEL'(1) << index;
  endfunction

endpackage

// File: rtl/apb_wait_timer6.sv
// Counts ACCESS cycles with pready6 low; expired flags the cycle the count hits the limit.
module apb_wait_timer6 #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic pclock6,
  input  logic preset6,
  input  logic clear,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] count_q, count_d, count_now;

      // count_now includes the current stalled cycle, so the abort lands on
      // exactly the TIMEOUT_CYCLES-th low cycle and a ready in that cycle wins.
      always_comb begin
        count_now = count_q + CW'(en);
        count_d   = clear ? '0 : count_now;
      end

      assign expired = en && (count_now == LIMIT);

      always_ff @(posedge pclock6 or negedge preset6) begin
        if (!preset6) count_q <= '0;
        else          count_q <= count_d;
      end
    end
  endgenerate

endmodule

// File: rtl/apb_req_bridge6.sv
// Single-outstanding valid/ready request to APB transfer bridge with slave decode and wait timeout.
module apb_req_bridge6
  import apb_bridge_pkg6::*;
#(
  parameter int PADDR_WIDTH6   = 32,
  parameter int PWDATA_WIDTH6  = 32,
  parameter int PRDATA_WIDTH6  = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     pclock6,
  input  logic                     preset6,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PADDR_WIDTH6-1:0]  req_addr,
  input  logic                     req_write,
  input  logic [PWDATA_WIDTH6-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PRDATA_WIDTH6-1:0] rsp_rdata,
  output logic                     rsp_slverr,
  output logic                     rsp_timeout,
  output logic [PADDR_WIDTH6-1:0]  paddr6,
  output logic                     prwd6,
  output logic [PWDATA_WIDTH6-1:0] pwdata6,
  output logic [NUM_SEL-1:0]       psel6,
  output logic                     penable6,
  input  logic                     pready6,
  input  logic [PRDATA_WIDTH6-1:0] prdata6,
  input  logic                     pslverr6
);

  apb_br_state_e state_q, state_d;

  logic [PADDR_WIDTH6-1:0]  paddr_q, paddr_d;
  logic                     prwd_q, prwd_d;
  logic [PWDATA_WIDTH6-1:0] pwdata_q, pwdata_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [PRDATA_WIDTH6-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_slverr_q, rsp_slverr_d;
  logic                     rsp_timeout_q, rsp_timeout_d;

  logic [SEL_BITS-1:0] req_idx, cur_idx;
  logic                dec_err;
  logic                tmo_en, tmo_clear, tmo_expired;

  assign req_idx = req_addr[SEL_LSB +: SEL_BITS];
  assign cur_idx = paddr_q[SEL_LSB +: SEL_BITS];
  assign dec_err = ({1'b0, req_idx} >= 5'(NUM_SLAVES));

  assign tmo_en    = (state_q == ACCESS) && !pready6;
  assign tmo_clear = (state_d != ACCESS);

  apb_wait_timer6 #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .pclock6 (pclock6),
    .preset6 (preset6),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    prwd_d        = prwd_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          prwd_d   = req_write;
          pwdata_d = req_write ? req_wdata : '0;
          // Unpopulated slot: answer with an error without touching the bus.
          if (dec_err) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready6) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = pslverr6;
          rsp_rdata_d   = (!prwd_q && !pslverr6) ? prdata6 : '0;
          rsp_timeout_d = 1'b0;
        end else if (tmo_expired) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclock6 or negedge preset6) begin
    if (!preset6) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      prwd_q        <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      prwd_q        <= prwd_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus controls decode straight from the state flop so reset drops them at once.
  assign psel6       = ((state_q == SETUP) || (state_q == ACCESS)) ? decode_psel(cur_idx) : '0;
  assign penable6    = (state_q == ACCESS);
  assign req_ready   = (state_q == IDLE);
  assign paddr6      = paddr_q;
  assign prwd6       = prwd_q;
  assign pwdata6     = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_bridge6.sv
// Self-checking bench for apb_req_bridge6: directed scenarios plus randomized transfers vs a transaction-level model.
module tb_apb_req_bridge6;

  localparam int TO = 8;
  localparam int NS = 4;

  logic        pclock6 = 1'b0;
  logic        preset6;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr6, pwdata6, prdata6;
  logic        prwd6, penable6, pready6, pslverr6;
  logic [15:0] psel6;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclock6 = ~pclock6;

  apb_req_bridge6 #(
    .PADDR_WIDTH6(32), .PWDATA_WIDTH6(32), .PRDATA_WIDTH6(32),
    .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclock6(pclock6), .preset6(preset6),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr6(paddr6), .prwd6(prwd6), .pwdata6(pwdata6), .psel6(psel6),
    .penable6(penable6), .pready6(pready6), .prdata6(prdata6), .pslverr6(pslverr6)
  );

  typedef struct {
    int          lat;
    int          psel_n;
    int          pen_n;
    logic [15:0] psel_or;
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
    bit          bus_bad;
    bit          unstable;
    bit          ready_bad;
    bit          hold_bad;
    bit          clr_ok;
  } obs_t;

  typedef struct {
    int          lat;
    int          psel_n;
    int          pen_n;
    logic [15:0] psel;
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  // Transaction-level expectation: one decode, then SETUP + ACCESS cycles.
  function automatic exp_t model(input logic [31:0] addr, input logic wr,
                                 input int waits, input logic serr, input logic [31:0] rd);
    exp_t e;
    int idx = int'(addr[15:12]);
    bit dec = (idx >= NS);
    bit to  = !dec && (waits >= TO);
    int acc = to ? TO : waits + 1;
    e.lat     = dec ? 1 : 2 + acc;
    e.psel_n  = dec ? 0 : acc + 1;
    e.pen_n   = dec ? 0 : acc;
    e.psel    = dec ? 16'h0 : (16'h1 << idx);
    e.slverr  = dec || to || serr;
    e.timeout = to;
    e.rdata   = (!wr && !e.slverr) ? rd : 32'h0;
    return e;
  endfunction

  // Drives one request, plays the slave, and records what the bus and response did.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int waits, input logic serr, input logic [31:0] rd,
                         input int hold, output obs_t o);
    int  held = 0;
    bit  seen = 0;
    bit  done = 0;
    int  cyc  = 0;
    logic [31:0] wd_exp = wr ? wd : 32'h0;
    o = '{lat: -1, psel_n: 0, pen_n: 0, psel_or: 16'h0, rdata: 32'h0, slverr: 1'b0,
          timeout: 1'b0, bus_bad: 0, unstable: 0, ready_bad: 0, hold_bad: 0, clr_ok: 0};
    @(negedge pclock6);
    if (req_ready !== 1'b1) o.ready_bad = 1;
    req_valid = 1; req_addr = addr; req_write = wr; req_wdata = wd;
    rsp_ready = (hold == 0); pready6 = 0;
    @(posedge pclock6);
    while (!done && cyc < 40) begin
      @(negedge pclock6);
      cyc++;
      req_valid = 0; req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
      if (req_ready !== 1'b0) o.ready_bad = 1;
      if (psel6 !== 16'h0) begin
        o.psel_n++;
        o.psel_or |= psel6;
        if ($countones(psel6) != 1) o.bus_bad = 1;
        if (paddr6 !== addr || prwd6 !== wr || pwdata6 !== wd_exp) o.unstable = 1;
      end
      if (penable6 === 1'b1) begin
        o.pen_n++;
        if (psel6 === 16'h0) o.bus_bad = 1;
      end
      pready6  = (penable6 === 1'b1) && (o.pen_n == waits + 1);
      prdata6  = pready6 ? rd : $urandom;
      pslverr6 = pready6 ? serr : 1'($urandom);
      if (rsp_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; o.lat = cyc;
          o.rdata = rsp_rdata; o.slverr = rsp_slverr; o.timeout = rsp_timeout;
        end else if (rsp_rdata !== o.rdata || rsp_slverr !== o.slverr || rsp_timeout !== o.timeout) begin
          o.hold_bad = 1;
        end
        if (held >= hold) begin
          rsp_ready = 1;
          @(posedge pclock6);
          @(negedge pclock6);
          o.clr_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
          done = 1;
        end else begin
          rsp_ready = 0;
          held++;
        end
      end
    end
    pready6 = 0;
  endtask

  task automatic test_reset;
    vectors++;
    if (psel6 !== 16'h0 || penable6 !== 1'b0 || paddr6 !== 32'h0 || prwd6 !== 1'b0 || pwdata6 !== 32'h0) begin
      miscompares++; $display("FAIL reset_bus: psel=%h pen=%b paddr=%h prwd=%b pwdata=%h want all 0", psel6, penable6, paddr6, prwd6, pwdata6);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp: valid=%b rdata=%h slverr=%b tmo=%b want all 0", rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout);
    end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read_zero_wait;
    obs_t o;
    run_txn(32'h0000_3004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 0, o);
    vectors++; if (o.lat !== 3) begin miscompares++; $display("FAIL rd0_latency: got %0d want 3", o.lat); end
    vectors++; if (o.psel_or !== 16'h0008 || o.psel_n !== 2) begin miscompares++; $display("FAIL rd0_psel: got %h x%0d want 0008 x2", o.psel_or, o.psel_n); end
    vectors++; if (o.pen_n !== 1) begin miscompares++; $display("FAIL rd0_penable: got %0d want 1", o.pen_n); end
    vectors++; if (o.rdata !== 32'hDEAD_BEEF || o.slverr !== 1'b0) begin miscompares++; $display("FAIL rd0_rsp: got %h/%b want deadbeef/0", o.rdata, o.slverr); end
    vectors++; if (o.clr_ok !== 1'b1) begin miscompares++; $display("FAIL rd0_clear: got %b want 1", o.clr_ok); end
  endtask

  task automatic test_write_wait;
    obs_t o;
    run_txn(32'h0000_0010, 1'b1, 32'hA5A5_0001, 3, 1'b0, 32'h1234_5678, 0, o);
    vectors++; if (o.psel_or !== 16'h0001) begin miscompares++; $display("FAIL wr3_psel: got %h want 0001", o.psel_or); end
    vectors++; if (o.pen_n !== 4) begin miscompares++; $display("FAIL wr3_penable: got %0d want 4", o.pen_n); end
    vectors++; if (o.unstable !== 1'b0) begin miscompares++; $display("FAIL wr3_stable: got %b want 0", o.unstable); end
    vectors++; if (o.rdata !== 32'h0 || o.slverr !== 1'b0 || o.lat !== 6) begin miscompares++; $display("FAIL wr3_rsp: got %h/%b lat %0d want 0/0 lat 6", o.rdata, o.slverr, o.lat); end
  endtask

  task automatic test_slverr_hold;
    obs_t o;
    run_txn(32'h0000_1020, 1'b0, 32'h0, 0, 1'b1, 32'hFFFF_0000, 5, o);
    vectors++; if (o.slverr !== 1'b1 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL serr_rsp: got %b/%h want 1/0", o.slverr, o.rdata); end
    vectors++; if (o.hold_bad !== 1'b0) begin miscompares++; $display("FAIL serr_hold: got %b want 0", o.hold_bad); end
    vectors++; if (o.ready_bad !== 1'b0) begin miscompares++; $display("FAIL serr_req_ready: got %b want 0", o.ready_bad); end
    vectors++; if (o.clr_ok !== 1'b1) begin miscompares++; $display("FAIL serr_clear: got %b want 1", o.clr_ok); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_txn(32'h0000_2000, 1'b0, 32'h0, 1000, 1'b0, 32'h5555_AAAA, 0, o);
    vectors++; if (o.pen_n !== TO || o.lat !== TO + 2) begin miscompares++; $display("FAIL tmo_cycles: got pen %0d lat %0d want %0d/%0d", o.pen_n, o.lat, TO, TO + 2); end
    vectors++; if (o.timeout !== 1'b1 || o.slverr !== 1'b1 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL tmo_rsp: got t%b e%b %h want t1 e1 0", o.timeout, o.slverr, o.rdata); end
    vectors++; if (o.bus_bad !== 1'b0) begin miscompares++; $display("FAIL tmo_bus: got %b want 0", o.bus_bad); end
    run_txn(32'h0000_2000, 1'b0, 32'h0, TO - 1, 1'b0, 32'h5555_AAAA, 0, o);
    vectors++; if (o.timeout !== 1'b0 || o.slverr !== 1'b0 || o.rdata !== 32'h5555_AAAA) begin miscompares++; $display("FAIL tmo_edge: got t%b e%b %h want t0 e0 5555aaaa", o.timeout, o.slverr, o.rdata); end
    vectors++; if (o.pen_n !== TO) begin miscompares++; $display("FAIL tmo_edge_pen: got %0d want %0d", o.pen_n, TO); end
  endtask

  task automatic test_decode_err;
    obs_t o;
    run_txn(32'h0000_5000, 1'b1, 32'h0BAD_0BAD, 0, 1'b0, 32'h0, 0, o);
    vectors++; if (o.psel_n !== 0 || o.pen_n !== 0) begin miscompares++; $display("FAIL dec_bus: got psel %0d pen %0d want 0/0", o.psel_n, o.pen_n); end
    vectors++; if (o.lat !== 1 || o.slverr !== 1'b1 || o.timeout !== 1'b0) begin miscompares++; $display("FAIL dec_rsp: got lat %0d e%b t%b want 1 e1 t0", o.lat, o.slverr, o.timeout); end
  endtask

  task automatic test_reset_access;
    obs_t o;
    @(negedge pclock6);
    req_valid = 1; req_addr = 32'h0000_2008; req_write = 0; req_wdata = 0; pready6 = 0; rsp_ready = 1;
    @(posedge pclock6);
    @(negedge pclock6); req_valid = 0;
    repeat (2) @(negedge pclock6);
    vectors++; if (penable6 !== 1'b1) begin miscompares++; $display("FAIL rst_pre_access: got %b want 1", penable6); end
    #2 preset6 = 0;
    #1;
    vectors++;
    if (psel6 !== 16'h0 || penable6 !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_async: psel=%h pen=%b rspv=%b want 0", psel6, penable6, rsp_valid);
    end
    repeat (2) @(posedge pclock6);
    @(negedge pclock6) preset6 = 1;
    #1;
    vectors++; if (req_ready !== 1'b1 || paddr6 !== 32'h0) begin miscompares++; $display("FAIL rst_release: ready=%b paddr=%h want 1/0", req_ready, paddr6); end
    run_txn(32'h0000_1000, 1'b0, 32'h0, 1, 1'b0, 32'hC0FF_EE00, 0, o);
    vectors++; if (o.rdata !== 32'hC0FF_EE00 || o.lat !== 4 || o.slverr !== 1'b0) begin miscompares++; $display("FAIL rst_next_read: got %h lat %0d e%b want c0ffee00 lat 4 e0", o.rdata, o.lat, o.slverr); end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr = $urandom;
      logic        wr   = 1'($urandom);
      logic [31:0] wd   = $urandom;
      logic [31:0] rd   = $urandom;
      int          wt   = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
      logic        se   = ($urandom_range(0, 3) == 0);
      int          hd   = $urandom_range(0, 2);
      addr[15:12] = 4'($urandom_range(0, 5));
      e = model(addr, wr, wt, se, rd);
      run_txn(addr, wr, wd, wt, se, rd, hd, o);
      vectors++;
      if (o.lat !== e.lat || o.psel_n !== e.psel_n || o.pen_n !== e.pen_n || o.psel_or !== e.psel) begin
        miscompares++;
        $display("FAIL rnd%0d_bus: lat %0d psel %h x%0d pen %0d want lat %0d psel %h x%0d pen %0d",
                 n, o.lat, o.psel_or, o.psel_n, o.pen_n, e.lat, e.psel, e.psel_n, e.pen_n);
      end
      vectors++;
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.timeout !== e.timeout) begin
        miscompares++;
        $display("FAIL rnd%0d_rsp: got %h e%b t%b want %h e%b t%b", n, o.rdata, o.slverr, o.timeout, e.rdata, e.slverr, e.timeout);
      end
      vectors++;
      if (o.bus_bad || o.unstable || o.ready_bad || o.hold_bad || !o.clr_ok) begin
        miscompares++;
        $display("FAIL rnd%0d_protocol: bus %b unstable %b ready %b hold %b clr %b want 0 0 0 0 1",
                 n, o.bus_bad, o.unstable, o.ready_bad, o.hold_bad, o.clr_ok);
      end
    end
  endtask

  initial begin
    preset6 = 0; req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0;
    rsp_ready = 0; pready6 = 0; prdata6 = 0; pslverr6 = 0;
    repeat (3) @(posedge pclock6);
    @(negedge pclock6);
    test_reset;
    preset6 = 1;
    test_read_zero_wait;
    test_write_wait;
    test_slverr_hold;
    test_timeout;
    test_decode_err;
    test_reset_access;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
